// File: rtl/debug_in.sv
// Host-to-core debug write port: synchronizes a 4-phase strobe/ack byte handshake
// and assembles low/high byte pairs into single-cycle 16-bit target writes.
module debug_in #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
  input  logic [7:0]  hostData,
  input  logic [2:0]  inSel,
  input  logic        highSe,
  input  logic        errClr,
  output logic        ack,
  output logic        outWe,
  output logic [2:0]  outSel,
  output logic [15:0] outData,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, LOW_HELD, COMMIT} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_s;
  logic                   strobe_d;
  logic                   capture;
  logic [7:0]             low_byte;
  logic [2:0]             low_sel;
  logic [15:0]            cnt;

  assign strobe_s = sync_q[SYNC_STAGES-1];
  assign capture  = strobe_s & ~strobe_d & ~ack;
  assign busy     = (state == LOW_HELD);

  // Strobe synchronizer: strobe crosses into the clk domain here
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
    end
  end

  // Handshake, byte assembly and write issue
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      strobe_d <= 1'b0;
      ack      <= 1'b0;
      outWe    <= 1'b0;
      outSel   <= '0;
      outData  <= '0;
      err      <= 1'b0;
      low_byte <= '0;
      low_sel  <= '0;
      cnt      <= '0;
    end else begin
      strobe_d <= strobe_s;
      if (!strobe_s) begin
        ack <= 1'b0;
      end else if (capture) begin
        ack <= 1'b1;
      end

      // A new error assigned below overrides a same-cycle clear.
      if (errClr) begin
        err <= 1'b0;
      end
      outWe <= 1'b0;

      case (state)
        IDLE: begin
          if (capture) begin
            if (highSe) begin
              err <= 1'b1;
            end else begin
              low_byte <= hostData;
              low_sel  <= inSel;
              cnt      <= '0;
              state    <= LOW_HELD;
            end
          end
        end
        LOW_HELD: begin
          cnt <= cnt + 16'd1;
          if (capture) begin
            if (!highSe) begin
              low_byte <= hostData;
              low_sel  <= inSel;
              cnt      <= '0;
            end else if (inSel == low_sel) begin
              outWe   <= 1'b1;
              outSel  <= low_sel;
              outData <= {hostData, low_byte};
              state   <= COMMIT;
            end else begin
              err   <= 1'b1;
              state <= IDLE;
            end
          end else if (cnt == CNT_LAST) begin
            err   <= 1'b1;
            state <= IDLE;
          end
        end
        COMMIT: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_in.sv
// Directed bench for debug_in: host byte writes through the strobe/ack handshake.
module tb_debug_in;

  logic        clk = 1'b0;
  logic        rst;
  logic        strobe;
  logic [7:0]  hostData;
  logic [2:0]  inSel;
  logic        highSe;
  logic        errClr;
  logic        ack;
  logic        outWe;
  logic [2:0]  outSel;
  logic [15:0] outData;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int we_cnt = 0;
  int busy_cnt = 0;
  logic [2:0]  last_sel = '0;
  logic [15:0] last_data = '0;

  always #5 clk = ~clk;

  debug_in #(.SYNC_STAGES(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .hostData(hostData), .inSel(inSel),
    .highSe(highSe), .errClr(errClr), .ack(ack), .outWe(outWe), .outSel(outSel),
    .outData(outData), .busy(busy), .err(err)
  );

  always @(negedge clk) begin
    if (outWe === 1'b1) begin
      we_cnt++;
      last_sel = outSel;
      last_data = outData;
    end
    if (busy === 1'b1) busy_cnt++;
  end

  task tick();
    @(posedge clk);
    #1;
  endtask

  task host_write(input logic [7:0] d, input logic [2:0] s, input logic hs,
                  output int lat, output logic we_at_ack, output logic ok);
    int n;
    ok = 1'b1;
    hostData = d; inSel = s; highSe = hs; strobe = 1'b1;
    n = 0;
    while (ack !== 1'b1 && n < 10) begin tick(); n++; end
    lat = n;
    we_at_ack = outWe;
    if (n >= 10) begin
      ok = 1'b0; checks++; errors++;
      $display("FAIL ack_rise: ack=%b after %0d clks, required 1", ack, n);
    end
    strobe = 1'b0;
    n = 0;
    while (ack !== 1'b0 && n < 10) begin tick(); n++; end
    if (n >= 10) begin
      ok = 1'b0; checks++; errors++;
      $display("FAIL ack_fall: ack=%b after %0d clks, required 0", ack, n);
    end
  endtask

  task clear_err();
    errClr = 1'b1; tick(); errClr = 1'b0;
  endtask

  task test_reset();
    rst = 1'b0; strobe = 1'b0; errClr = 1'b0; hostData = '0; inSel = '0; highSe = 1'b0;
    tick(); tick();
    checks++;
    if ({ack, outWe, outSel, outData, busy, err} !== 23'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {ack, outWe, outSel, outData, busy, err});
    end
    rst = 1'b1;
    tick();
  endtask

  task test_write_pair();
    int lat, w0; logic wa, ok, inrange;
    w0 = we_cnt;
    host_write(8'h34, 3'd5, 1'b0, lat, wa, ok);
    inrange = (lat >= 3 && lat <= 4);
    checks++;
    if (inrange !== 1'b1) begin errors++; $display("FAIL ack_latency: got %0d required 3..4", lat); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL pair_busy_low: got %b required 1", busy); end
    host_write(8'h12, 3'd5, 1'b1, lat, wa, ok);
    checks++;
    if (wa !== 1'b1) begin errors++; $display("FAIL pair_we_timing: outWe at ack %b required 1", wa); end
    checks++;
    if (we_cnt - w0 !== 1) begin errors++; $display("FAIL pair_we_count: got %0d required 1", we_cnt - w0); end
    checks++;
    if (last_sel !== 3'd5) begin errors++; $display("FAIL pair_sel: got %0d required 5", last_sel); end
    checks++;
    if (last_data !== 16'h1234) begin errors++; $display("FAIL pair_data: got %h required 1234", last_data); end
    checks++;
    if (outData !== 16'h1234) begin errors++; $display("FAIL pair_hold: got %h required 1234", outData); end
    checks++;
    if ({err, busy, outWe} !== 3'b000) begin errors++; $display("FAIL pair_status: err/busy/we %b required 000", {err, busy, outWe}); end
  endtask

  task test_high_from_idle();
    int lat, w0; logic wa, ok;
    w0 = we_cnt;
    host_write(8'hAB, 3'd2, 1'b1, lat, wa, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL idle_high_handshake: got %b required 1", ok); end
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL idle_high_err: got %b required 1", err); end
    checks++;
    if (we_cnt != w0) begin errors++; $display("FAIL idle_high_we: got %0d pulses required 0", we_cnt - w0); end
    clear_err();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b required 0", err); end
  endtask

  task test_sel_mismatch();
    int lat, w0; logic wa, ok;
    w0 = we_cnt;
    host_write(8'h11, 3'd3, 1'b0, lat, wa, ok);
    host_write(8'h22, 3'd4, 1'b1, lat, wa, ok);
    checks++;
    if ({err, busy} !== 2'b10) begin errors++; $display("FAIL mismatch_status: err/busy %b required 10", {err, busy}); end
    checks++;
    if (we_cnt != w0) begin errors++; $display("FAIL mismatch_we: got %0d pulses required 0", we_cnt - w0); end
    clear_err();
  endtask

  task test_timeout();
    int lat, w0; logic wa, ok;
    w0 = we_cnt;
    busy_cnt = 0;
    host_write(8'h55, 3'd1, 1'b0, lat, wa, ok);
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (busy_cnt != 8) begin errors++; $display("FAIL timeout_len: busy for %0d clks required 8", busy_cnt); end
    checks++;
    if ({err, busy} !== 2'b10) begin errors++; $display("FAIL timeout_status: err/busy %b required 10", {err, busy}); end
    clear_err();
    host_write(8'h66, 3'd1, 1'b1, lat, wa, ok);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL late_high_err: got %b required 1", err); end
    checks++;
    if (we_cnt != w0) begin errors++; $display("FAIL timeout_we: got %0d pulses required 0", we_cnt - w0); end
    clear_err();
  endtask

  task test_overwrite_and_clear();
    int lat, w0, n; logic wa, ok;
    w0 = we_cnt;
    host_write(8'h01, 3'd7, 1'b0, lat, wa, ok);
    host_write(8'h02, 3'd7, 1'b0, lat, wa, ok);
    host_write(8'h03, 3'd7, 1'b1, lat, wa, ok);
    checks++;
    if (we_cnt - w0 !== 1) begin errors++; $display("FAIL overwrite_we: got %0d required 1", we_cnt - w0); end
    checks++;
    if ({last_sel, last_data} !== {3'd7, 16'h0302}) begin
      errors++; $display("FAIL overwrite_data: got sel %0d data %h required 7 0302", last_sel, last_data);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL overwrite_err: got %b required 0", err); end
    // errClr asserted exactly on the capture cycle of an erroneous high byte
    hostData = 8'h44; inSel = 3'd0; highSe = 1'b1; strobe = 1'b1;
    tick(); tick(); errClr = 1'b1; tick(); errClr = 1'b0;
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL set_wins: got %b required 1", err); end
    strobe = 1'b0;
    n = 0;
    while (ack !== 1'b0 && n < 10) begin tick(); n++; end
    clear_err();
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL clear_after_set: got %b required 0", err); end
  endtask

  task test_reset_mid();
    int lat, w0, n; logic wa, ok;
    host_write(8'h66, 3'd0, 1'b0, lat, wa, ok);
    rst = 1'b0; tick(); rst = 1'b1;
    checks++;
    if ({ack, outWe, outSel, outData, busy, err} !== 23'd0) begin
      errors++; $display("FAIL reset_low_held: got %h required 0", {ack, outWe, outSel, outData, busy, err});
    end
    w0 = we_cnt;
    for (int i = 0; i < 12; i++) tick();
    checks++;
    if ({we_cnt != w0, err, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_discard: we/err/busy %b required 000", {we_cnt != w0, err, busy});
    end
    host_write(8'h77, 3'd6, 1'b0, lat, wa, ok);
    hostData = 8'h88; inSel = 3'd6; highSe = 1'b1; strobe = 1'b1;
    n = 0;
    while (ack !== 1'b1 && n < 10) begin tick(); n++; end
    checks++;
    if (outWe !== 1'b1) begin errors++; $display("FAIL commit_reached: outWe %b required 1", outWe); end
    rst = 1'b0; strobe = 1'b0; tick(); rst = 1'b1;
    checks++;
    if ({ack, outWe, outSel, outData, busy, err} !== 23'd0) begin
      errors++; $display("FAIL reset_commit: got %h required 0", {ack, outWe, outSel, outData, busy, err});
    end
    for (int i = 0; i < 6; i++) tick();
    host_write(8'h99, 3'd6, 1'b1, lat, wa, ok);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL post_reset_high_err: got %b required 1", err); end
    clear_err();
    w0 = we_cnt;
    host_write(8'h9A, 3'd2, 1'b0, lat, wa, ok);
    host_write(8'hBC, 3'd2, 1'b1, lat, wa, ok);
    checks++;
    if ({we_cnt - w0 == 1, last_sel, last_data, err} !== {1'b1, 3'd2, 16'hBC9A, 1'b0}) begin
      errors++; $display("FAIL post_reset_pair: pulses %0d sel %0d data %h err %b required 1 2 bc9a 0",
                         we_cnt - w0, last_sel, last_data, err);
    end
  endtask

  initial begin
    test_reset();
    test_write_pair();
    test_high_from_idle();
    test_sel_mismatch();
    test_timeout();
    test_overwrite_and_clear();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
